// File: rtl/udp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp_pkg
// Description : Shared definitions for the UDP transmit packer: FSM state
//               encoding, default packet/timeout constants and a ceil-log2
//               helper used to size FIFO pointers and counters.
// Revision    : 1.0 - initial release
// ============================================================================
package udp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int c_PKT_BYTES_DEF  = 1024;
    localparam int c_FIFO_DEPTH_DEF = 1024;
    localparam int c_TIMEOUT_DEF    = 125000;

    // Smallest r with 2**r >= value (value >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_w32.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_w32
// Description : Single-clock 32-bit FIFO with occupancy output. The head word
//               is presented combinationally on o_dout; a pop advances it.
//               Push and pop in one cycle leave the count unchanged. Pops on
//               empty and pushes on full are ignored.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               i_push/i_din - write strobe and data
//               i_pop/o_dout - read strobe and head word
//               o_count      - words held (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_w32
    import udp_pkg::*;
#(
    parameter int DEPTH = 1024
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [31:0]            i_din,
    input  logic                   i_pop,
    output logic [31:0]            o_dout,
    output logic [clog2(DEPTH):0]  o_count
);

    localparam int              c_AW   = clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

    logic [31:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    // A push into a full FIFO is still fine when a pop frees a slot this cycle.
    assign w_push  = i_push && ((r_count != c_FULL) || w_pop);
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/udp_tx_packer.sv
`default_nettype none
// ============================================================================
// Module      : udp_tx_packer
// Description : Packs an input byte stream big-endian into 32-bit words,
//               buffers them, and hands full PKT_BYTES packets (or, after
//               TIMEOUT idle cycles, a short flush packet) to the UDP user
//               transmit interface.
// Ports       : clk, rst_n         - gmii_tx_clk, asynchronous active-low reset
//               din_valid/din/din_ready - byte input handshake
//               tx_start_en/tx_byte_num - packet request and payload length
//               tx_req/tx_data     - word request and returned payload word
//               tx_done            - packet-complete pulse from udp
//               underflow_err      - sticky tx_req-on-empty flag
//               pkt_cnt            - completed packet counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_packer
    import udp_pkg::*;
#(
    parameter int PKT_BYTES  = c_PKT_BYTES_DEF,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH_DEF,
    parameter int TIMEOUT    = c_TIMEOUT_DEF
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_valid,
    input  logic [7:0]  din,
    output logic        din_ready,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    output logic [31:0] tx_data,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic        underflow_err,
    output logic [15:0] pkt_cnt
);

    localparam int               c_CW        = clog2(FIFO_DEPTH) + 1;
    localparam int               c_TW        = clog2(TIMEOUT + 1);
    localparam logic [c_CW-1:0]  c_PKT_WORDS = c_CW'(PKT_BYTES / 4);
    localparam logic [c_CW-1:0]  c_READY_LIM = c_CW'(FIFO_DEPTH - 1);
    localparam logic [c_TW-1:0]  c_TMO       = c_TW'(TIMEOUT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [23:0]     r_hold;        // first byte of a word sits in [23:16]
    logic [1:0]      r_nbytes;      // bytes currently held (0..3)
    logic [c_TW-1:0] r_tmo;
    logic [15:0]     r_byte_num;
    logic [15:0]     w_byte_num_nxt;
    logic [15:0]     r_pkt_cnt;
    logic [31:0]     r_tx_data;
    logic            r_underflow;
    logic            r_alive;       // keeps din_ready low while in reset

    logic [c_CW-1:0] w_count;
    logic [31:0]     w_fifo_dout;
    logic [31:0]     w_push_data;
    logic [15:0]     w_flush_num;
    logic            w_accept;
    logic            w_has_data;
    logic            w_full_pkt;
    logic            w_flush;
    logic            w_partial_push;
    logic            w_word_push;
    logic            w_push;
    logic            w_pop;

    // One slot is always kept free so a timeout flush can push its partial word.
    assign din_ready      = r_alive && (w_count < c_READY_LIM);
    assign w_accept       = din_valid && din_ready;
    assign w_has_data     = (w_count != '0) || (r_nbytes != 2'd0);
    assign w_full_pkt     = (r_state == ST_IDLE) && (w_count >= c_PKT_WORDS);
    assign w_flush        = (r_state == ST_IDLE) && !w_full_pkt &&
                            (r_tmo == c_TMO) && w_has_data;
    // The flush word owns the push port; a byte accepted alongside it starts a new word.
    assign w_partial_push = w_flush && (r_nbytes != 2'd0);
    assign w_word_push    = w_accept && (r_nbytes == 2'd3) && !w_partial_push;
    assign w_push         = w_partial_push || w_word_push;
    assign w_push_data    = w_partial_push ? {r_hold, 8'h00} : {r_hold, din};
    assign w_pop          = (r_state == ST_SEND) && tx_req && (w_count != '0);
    // {count, nbytes} == count*4 + partial bytes, using the pre-push count.
    assign w_flush_num    = 16'({w_count, r_nbytes});

    assign tx_byte_num    = r_byte_num;
    assign tx_data        = r_tx_data;
    assign underflow_err  = r_underflow;
    assign pkt_cnt        = r_pkt_cnt;

    sync_fifo_w32 #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_byte_num_nxt = r_byte_num;
        tx_start_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_full_pkt) begin
                    w_state_nxt    = ST_START;
                    w_byte_num_nxt = 16'(PKT_BYTES);
                end else if (w_flush) begin
                    w_state_nxt    = ST_START;
                    w_byte_num_nxt = w_flush_num;
                end
            end
            ST_START: begin
                tx_start_en = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (tx_done) w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_nbytes    <= 2'd0;
            r_tmo       <= '0;
            r_byte_num  <= '0;
            r_pkt_cnt   <= '0;
            r_tx_data   <= '0;
            r_underflow <= 1'b0;
            r_alive     <= 1'b0;
        end else begin
            r_alive    <= 1'b1;
            r_byte_num <= w_byte_num_nxt;
            if (r_state == ST_DONE) r_pkt_cnt <= r_pkt_cnt + 16'd1;
            if (w_pop) r_tx_data <= w_fifo_dout;
            if ((r_state == ST_SEND) && tx_req && (w_count == '0)) r_underflow <= 1'b1;

            if (w_partial_push) begin
                r_hold   <= w_accept ? {din, 16'h0000} : 24'h0;
                r_nbytes <= w_accept ? 2'd1 : 2'd0;
            end else if (w_accept) begin
                case (r_nbytes)
                    2'd0:    r_hold <= {din, 16'h0000};
                    2'd1:    r_hold[15:8] <= din;
                    2'd2:    r_hold[7:0]  <= din;
                    default: r_hold <= 24'h0;
                endcase
                r_nbytes <= r_nbytes + 2'd1;
            end

            if ((r_state != ST_IDLE) || (w_state_nxt != ST_IDLE) || w_accept || !w_has_data)
                r_tmo <= '0;
            else if (r_tmo != c_TMO)
                r_tmo <= r_tmo + c_TW'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_tx_packer
// Description : Directed self-checking bench for udp_tx_packer with
//               PKT_BYTES=8, FIFO_DEPTH=8, TIMEOUT=100. Inputs change and
//               outputs are sampled on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_tx_packer;

    localparam int PKT_BYTES  = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int TIMEOUT    = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_valid = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        din_ready;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic [31:0] tx_data;
    logic        tx_req = 1'b0;
    logic        tx_done = 1'b0;
    logic        underflow_err;
    logic [15:0] pkt_cnt;

    int          errs = 0;
    int          checks = 0;
    logic [31:0] got [8];
    logic        ux_err;
    logic [31:0] ux_data;

    udp_tx_packer #(
        .PKT_BYTES     (PKT_BYTES),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din_valid     (din_valid),
        .din           (din),
        .din_ready     (din_ready),
        .tx_start_en   (tx_start_en),
        .tx_byte_num   (tx_byte_num),
        .tx_data       (tx_data),
        .tx_req        (tx_req),
        .tx_done       (tx_done),
        .underflow_err (underflow_err),
        .pkt_cnt       (pkt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errs);
        $fatal(1);
    end

    // Present one byte and hold it until the DUT accepts it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        din = b;
        din_valid = 1'b1;
        while (din_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (din_ready !== 1'b1) begin
            checks++; errs++;
            $display("FAIL send_byte timeout: din_ready=%b want 1", din_ready);
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    // Count falling edges until tx_start_en is seen (bounded).
    task automatic wait_start(input int budget, output int k);
        k = 0;
        while (tx_start_en !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Udp-side model: called with the DUT in SEND, requests nwords words,
    // optionally one extra request, then pulses tx_done and returns in IDLE.
    task automatic serve(input int nwords, input bit extra);
        for (int i = 0; i < nwords; i++) begin
            tx_req = 1'b1;
            @(negedge clk);
            got[i] = tx_data;
        end
        if (extra) begin
            tx_req = 1'b1;
            @(negedge clk);
            ux_err  = underflow_err;
            ux_data = tx_data;
        end
        tx_req  = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (din_ready !== 1'b0) begin errs++; $display("FAIL reset din_ready: got %b want 0", din_ready); end
        checks++; if (tx_start_en !== 1'b0) begin errs++; $display("FAIL reset tx_start_en: got %b want 0", tx_start_en); end
        checks++; if (tx_byte_num !== 16'd0) begin errs++; $display("FAIL reset tx_byte_num: got %0d want 0", tx_byte_num); end
        checks++; if (tx_data !== 32'd0) begin errs++; $display("FAIL reset tx_data: got %h want 0", tx_data); end
        checks++; if (underflow_err !== 1'b0) begin errs++; $display("FAIL reset underflow_err: got %b want 0", underflow_err); end
        checks++; if (pkt_cnt !== 16'd0) begin errs++; $display("FAIL reset pkt_cnt: got %0d want 0", pkt_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (din_ready !== 1'b1) begin errs++; $display("FAIL post-reset din_ready: got %b want 1", din_ready); end
    endtask

    task automatic test_full_packet();
        int k;
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        wait_start(2000, k);
        checks++; if (tx_start_en !== 1'b1) begin errs++; $display("FAIL full start: got %b want 1", tx_start_en); end
        checks++; if (k != 1) begin errs++; $display("FAIL full start latency: got %0d want 1", k); end
        checks++; if (tx_byte_num !== 16'd8) begin errs++; $display("FAIL full byte_num: got %0d want 8", tx_byte_num); end
        @(negedge clk);
        checks++; if (tx_start_en !== 1'b0) begin errs++; $display("FAIL full start pulse width: got %b want 0", tx_start_en); end
        serve(2, 1'b0);
        checks++; if (got[0] !== 32'h01020304) begin errs++; $display("FAIL full word0: got %h want 01020304", got[0]); end
        checks++; if (got[1] !== 32'h05060708) begin errs++; $display("FAIL full word1: got %h want 05060708", got[1]); end
        checks++; if (pkt_cnt !== 16'd1) begin errs++; $display("FAIL full pkt_cnt: got %0d want 1", pkt_cnt); end
        repeat (3) @(negedge clk);
        checks++; if (tx_start_en !== 1'b0) begin errs++; $display("FAIL full idle after done: start=%b want 0", tx_start_en); end
    endtask

    task automatic test_partial_flush();
        int k;
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        send_byte(8'hDD); send_byte(8'hEE);
        wait_start(2000, k);
        checks++; if (tx_start_en !== 1'b1) begin errs++; $display("FAIL flush start: got %b want 1", tx_start_en); end
        checks++; if (k != TIMEOUT + 1) begin errs++; $display("FAIL flush latency: got %0d want %0d", k, TIMEOUT + 1); end
        checks++; if (tx_byte_num !== 16'd5) begin errs++; $display("FAIL flush byte_num: got %0d want 5", tx_byte_num); end
        @(negedge clk);
        serve(2, 1'b0);
        checks++; if (got[0] !== 32'hAABBCCDD) begin errs++; $display("FAIL flush word0: got %h want aabbccdd", got[0]); end
        checks++; if (got[1] !== 32'hEE000000) begin errs++; $display("FAIL flush word1: got %h want ee000000", got[1]); end
        checks++; if (pkt_cnt !== 16'd2) begin errs++; $display("FAIL flush pkt_cnt: got %0d want 2", pkt_cnt); end
    endtask

    task automatic test_simultaneous();
        int k;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55);
        repeat (TIMEOUT) @(negedge clk);
        send_byte(8'hFF);   // lands exactly on the flush cycle
        checks++; if (tx_start_en !== 1'b1) begin errs++; $display("FAIL sim flush start: got %b want 1", tx_start_en); end
        checks++; if (tx_byte_num !== 16'd5) begin errs++; $display("FAIL sim flush byte_num: got %0d want 5", tx_byte_num); end
        @(negedge clk);
        fork
            begin
                for (int i = 1; i <= 8; i++) send_byte(8'(i));
            end
            begin
                serve(2, 1'b0);
            end
        join
        checks++; if (got[0] !== 32'h11223344) begin errs++; $display("FAIL sim flush word0: got %h want 11223344", got[0]); end
        checks++; if (got[1] !== 32'h55000000) begin errs++; $display("FAIL sim flush word1: got %h want 55000000", got[1]); end
        // Nine bytes are buffered: the full packet must win with exactly 8.
        wait_start(2000, k);
        checks++; if (tx_start_en !== 1'b1) begin errs++; $display("FAIL sim full start: got %b want 1", tx_start_en); end
        checks++; if (tx_byte_num !== 16'd8) begin errs++; $display("FAIL sim full byte_num: got %0d want 8", tx_byte_num); end
        @(negedge clk);
        serve(2, 1'b0);
        checks++; if (got[0] !== 32'hFF010203) begin errs++; $display("FAIL sim next word0: got %h want ff010203", got[0]); end
        checks++; if (got[1] !== 32'h04050607) begin errs++; $display("FAIL sim next word1: got %h want 04050607", got[1]); end
        wait_start(2000, k);
        checks++; if (tx_byte_num !== 16'd1 || tx_start_en !== 1'b1) begin errs++; $display("FAIL sim tail: start=%b byte_num=%0d want 1/1", tx_start_en, tx_byte_num); end
        @(negedge clk);
        serve(1, 1'b0);
        checks++; if (got[0] !== 32'h08000000) begin errs++; $display("FAIL sim tail word: got %h want 08000000", got[0]); end
        checks++; if (pkt_cnt !== 16'd5) begin errs++; $display("FAIL sim pkt_cnt: got %0d want 5", pkt_cnt); end
    endtask

    task automatic test_backpressure();
        int          acc;
        int          k;
        int          idx;
        int          nw;
        logic        rdy;
        logic [31:0] exp;
        acc = 0;
        for (int c = 0; c < 60; c++) begin
            din = 8'(32'h40 + acc);
            din_valid = 1'b1;
            rdy = din_ready;
            @(negedge clk);
            if (rdy) acc++;
        end
        din_valid = 1'b0;
        checks++; if (acc != 28) begin errs++; $display("FAIL bp accepted bytes: got %0d want 28", acc); end
        checks++; if (din_ready !== 1'b0) begin errs++; $display("FAIL bp din_ready when full: got %b want 0", din_ready); end
        idx = 0;
        for (int p = 0; p < 4; p++) begin
            nw = (p == 3) ? 1 : 2;
            if (p > 0) begin
                wait_start(2000, k);
                checks++; if (tx_start_en !== 1'b1) begin errs++; $display("FAIL bp start p%0d: got %b want 1", p, tx_start_en); end
                @(negedge clk);
            end
            checks++; if (tx_byte_num !== 16'(nw * 4)) begin errs++; $display("FAIL bp byte_num p%0d: got %0d want %0d", p, tx_byte_num, nw * 4); end
            serve(nw, 1'b0);
            for (int w = 0; w < nw; w++) begin
                exp = {8'(64 + 4 * idx), 8'(65 + 4 * idx), 8'(66 + 4 * idx), 8'(67 + 4 * idx)};
                checks++; if (got[w] !== exp) begin errs++; $display("FAIL bp word %0d: got %h want %h", idx, got[w], exp); end
                idx++;
            end
        end
        checks++; if (din_ready !== 1'b1) begin errs++; $display("FAIL bp din_ready after drain: got %b want 1", din_ready); end
        checks++; if (pkt_cnt !== 16'd9) begin errs++; $display("FAIL bp pkt_cnt: got %0d want 9", pkt_cnt); end
    endtask

    task automatic test_underflow();
        int k;
        for (int i = 1; i <= 8; i++) send_byte(8'(32'h80 + i));
        wait_start(2000, k);
        checks++; if (tx_byte_num !== 16'd8) begin errs++; $display("FAIL uf byte_num: got %0d want 8", tx_byte_num); end
        @(negedge clk);
        serve(2, 1'b1);
        checks++; if (got[1] !== 32'h85868788) begin errs++; $display("FAIL uf last word: got %h want 85868788", got[1]); end
        checks++; if (ux_err !== 1'b1) begin errs++; $display("FAIL uf flag: got %b want 1", ux_err); end
        checks++; if (ux_data !== 32'h85868788) begin errs++; $display("FAIL uf tx_data hold: got %h want 85868788", ux_data); end
        checks++; if (underflow_err !== 1'b1) begin errs++; $display("FAIL uf sticky: got %b want 1", underflow_err); end
        // An empty FIFO must stay empty: four new bytes flush as a 4-byte packet.
        send_byte(8'h91); send_byte(8'h92); send_byte(8'h93); send_byte(8'h94);
        wait_start(2000, k);
        checks++; if (tx_start_en !== 1'b1 || tx_byte_num !== 16'd4) begin errs++; $display("FAIL uf count: start=%b byte_num=%0d want 1/4", tx_start_en, tx_byte_num); end
        @(negedge clk);
        serve(1, 1'b0);
        checks++; if (got[0] !== 32'h91929394) begin errs++; $display("FAIL uf next word: got %h want 91929394", got[0]); end
        checks++; if (pkt_cnt !== 16'd11) begin errs++; $display("FAIL uf pkt_cnt: got %0d want 11", pkt_cnt); end
    endtask

    task automatic test_reset_mid_send();
        int k;
        for (int i = 1; i <= 8; i++) send_byte(8'(32'hC0 + i));
        wait_start(2000, k);
        @(negedge clk);
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        checks++; if (tx_data !== 32'hC1C2C3C4) begin errs++; $display("FAIL rst first word: got %h want c1c2c3c4", tx_data); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (din_ready !== 1'b0 || tx_start_en !== 1'b0) begin errs++; $display("FAIL rst handshake: ready=%b start=%b want 0/0", din_ready, tx_start_en); end
        checks++; if (tx_byte_num !== 16'd0 || tx_data !== 32'd0) begin errs++; $display("FAIL rst data: byte_num=%0d data=%h want 0/0", tx_byte_num, tx_data); end
        checks++; if (underflow_err !== 1'b0 || pkt_cnt !== 16'd0) begin errs++; $display("FAIL rst status: uf=%b pkt_cnt=%0d want 0/0", underflow_err, pkt_cnt); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_start(TIMEOUT + 50, k);
        checks++; if (tx_start_en !== 1'b0) begin errs++; $display("FAIL rst stale data: start=%b want 0", tx_start_en); end
        for (int i = 1; i <= 8; i++) send_byte(8'(32'hD0 + i));
        wait_start(2000, k);
        checks++; if (tx_start_en !== 1'b1 || tx_byte_num !== 16'd8) begin errs++; $display("FAIL rst fresh start: start=%b byte_num=%0d want 1/8", tx_start_en, tx_byte_num); end
        @(negedge clk);
        serve(2, 1'b0);
        checks++; if (got[0] !== 32'hD1D2D3D4) begin errs++; $display("FAIL rst fresh word0: got %h want d1d2d3d4", got[0]); end
        checks++; if (got[1] !== 32'hD5D6D7D8) begin errs++; $display("FAIL rst fresh word1: got %h want d5d6d7d8", got[1]); end
        checks++; if (pkt_cnt !== 16'd1) begin errs++; $display("FAIL rst fresh pkt_cnt: got %0d want 1", pkt_cnt); end
    endtask

    task automatic test_pkt_cnt_wrap();
        int k;
        force dut.r_pkt_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_pkt_cnt;
        @(negedge clk);
        checks++; if (pkt_cnt !== 16'hFFFF) begin errs++; $display("FAIL wrap preset: got %h want ffff", pkt_cnt); end
        for (int i = 1; i <= 8; i++) send_byte(8'(32'hE0 + i));
        wait_start(2000, k);
        @(negedge clk);
        serve(2, 1'b0);
        checks++; if (pkt_cnt !== 16'd0) begin errs++; $display("FAIL wrap pkt_cnt: got %0d want 0", pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_partial_flush();
        test_simultaneous();
        test_backpressure();
        test_underflow();
        test_reset_mid_send();
        test_pkt_cnt_wrap();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
